// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types for the pipeline stage buffer
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  typedef logic [1:0] pipe_occ_t;

  // Number of held entries given the main and skid slot valid bits.
  function automatic pipe_occ_t occ_of(input logic main_v, input logic skid_v);
    return pipe_occ_t'(main_v) + pipe_occ_t'(skid_v);
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one payload register with valid bit and clear-to-bubble
module pipe_slot #(
  parameter int                 DATA_W    = 64,
  parameter logic [DATA_W-1:0]  FLUSH_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              valid
);

  // Clear wins over load so a flush never lets a payload slip through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= FLUSH_VAL;
      valid <= 1'b0;
    end else if (clear) begin
      q     <= FLUSH_VAL;
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - valid/ready pipeline stage with optional skid slot and flush
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = 64,
  parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
  parameter bit                SKID      = 1'b1,
  parameter int                CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output pipe_occ_t         occupancy,
  output logic [CNT_W-1:0]  drop_cnt
);

  pipe_state_e       state, state_next;
  logic              push, pop;
  logic              main_load, main_clear, main_from_skid;
  logic              skid_load, skid_clear;
  logic [DATA_W-1:0] main_d, skid_q;
  logic              main_valid, skid_valid;
  logic [CNT_W:0]    drop_sum;
  pipe_occ_t         drop_add;

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_valid = main_valid;
  assign occupancy = occ_of(main_valid, skid_valid);
  assign main_d    = main_from_skid ? skid_q : in_data;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  // Next state and slot controls; flush overrides any push or pop.
  always_comb begin
    state_next     = state;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      state_next = EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state)
        EMPTY: if (push) begin
          state_next = BUSY;
          main_load  = 1'b1;
        end
        BUSY: begin
          if (push && !pop && SKID) begin
            state_next = FULL;
            skid_load  = 1'b1;
          end else if (push && pop) begin
            main_load = 1'b1;
          end else if (pop) begin
            state_next = EMPTY;
            main_clear = 1'b1;
          end
        end
        FULL: if (pop) begin
          state_next     = BUSY;
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_clear     = 1'b1;
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  pipe_slot #(.DATA_W(DATA_W), .FLUSH_VAL(FLUSH_VAL)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .q     (out_data),
    .valid (main_valid)
  );

  if (SKID) begin : g_skid
    logic ready_q;

    // Upstream ready is a flop: low exactly while both slots are held.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ready_q <= 1'b1;
      else        ready_q <= (state_next != FULL);
    end

    assign in_ready = ready_q;

    pipe_slot #(.DATA_W(DATA_W), .FLUSH_VAL(FLUSH_VAL)) u_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (skid_load),
      .clear (skid_clear),
      .d     (in_data),
      .q     (skid_q),
      .valid (skid_valid)
    );
  end else begin : g_noskid
    assign in_ready   = !main_valid | out_ready;
    assign skid_q     = FLUSH_VAL;
    assign skid_valid = 1'b0;
  end

  // A pop in the flush cycle still reaches downstream, so it is not a drop.
  assign drop_add = occupancy - pipe_occ_t'(pop);
  assign drop_sum = {1'b0, drop_cnt} + (CNT_W+1)'(drop_add);

  // Saturating count of entries killed by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     drop_cnt <= '0;
    else if (flush) drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
  end

endmodule
